// File: rtl/cpu_pkg.sv
// Shared register-file writeback types: address/data widths and the request
// carried through the load FIFO and the writeback output register.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of writeback requests.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_req_t          push_dat,
    input  logic             pop,
    output wb_req_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and buffered load responses onto the register-file write port.
// Latency: ALU 1 cycle to we/wa/wd; load minimum 2 cycles push-to-commit.
// Backpressure: ld_ready drops and alu_stall rises while the load FIFO is full.
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_stall,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    input  logic [REG_ADDR_W-1:0] q1_addr,
    input  logic [REG_ADDR_W-1:0] q2_addr,
    output logic                  q1_busy,
    output logic                  q2_busy,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [DATA_W-1:0]     wd
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_req_t          push_dat, head;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop, win;

    wb_req_t          out_q, out_d;
    logic             we_q, we_d;
    logic             src_ld_q, src_ld_d;
    logic [31:0]      sb_q, sb_d;

    assign ld_ready  = (count < CNT_W'(DEPTH));
    assign alu_stall = (count == CNT_W'(DEPTH));
    assign push      = ld_valid && ld_ready;
    assign push_dat  = '{addr: ld_addr, data: ld_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // A full FIFO outranks the ALU so loads always make forward progress.
    always_comb begin
        pop      = 1'b0;
        win      = 1'b0;
        out_d    = '0;
        src_ld_d = 1'b0;
        if (full) begin
            pop      = 1'b1;
            win      = 1'b1;
            out_d    = head;
            src_ld_d = 1'b1;
        end else if (alu_valid) begin
            win      = 1'b1;
            out_d    = '{addr: alu_addr, data: alu_data};
        end else if (!empty) begin
            pop      = 1'b1;
            win      = 1'b1;
            out_d    = head;
            src_ld_d = 1'b1;
        end
        we_d = win && (out_d.addr != '0);
    end

    // Clear happens first so a same-edge reservation of that register survives.
    always_comb begin
        sb_d = sb_q;
        if (we_q && src_ld_q) begin
            sb_d[wa] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            sb_d[rsv_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            we_q     <= 1'b0;
            src_ld_q <= 1'b0;
            sb_q     <= '0;
        end else begin
            out_q    <= out_d;
            we_q     <= we_d;
            src_ld_q <= src_ld_d;
            sb_q     <= sb_d;
        end
    end

    assign we      = we_q;
    assign wa      = out_q.addr;
    assign wd      = out_q.data;
    assign q1_busy = sb_q[q1_addr];
    assign q2_busy = sb_q[q2_addr];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: each task drives one scenario and
// compares outputs against hand-computed values one step after each clock edge.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        q1_busy;
    logic        q2_busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    writeback_arbiter #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .q1_addr   (q1_addr),
        .q2_addr   (q2_addr),
        .q1_busy   (q1_busy),
        .q2_busy   (q2_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        q1_addr = 5'd3; q2_addr = 5'd0;
        #1;
        total_cnt++;
        if ({we, wa, wd} !== {1'b0, 5'd0, 32'd0})
            $display("FAIL reset_wr: got we=%0b wa=%0d wd=%h want 0/0/0", we, wa, wd);
        else pass_cnt++;
        total_cnt++;
        if ({ld_ready, alu_stall, q1_busy, q2_busy} !== 4'b1000)
            $display("FAIL reset_flags: got rdy/stall/b1/b2=%b want 1000",
                     {ld_ready, alu_stall, q1_busy, q2_busy});
        else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        total_cnt++;
        if ({we, wa, wd} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL alu_write: got we=%0b wa=%0d wd=%h want 1/5/deadbeef", we, wa, wd);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (we !== 1'b0) $display("FAIL alu_idle: got we=%0b want 0", we);
        else pass_cnt++;
    endtask

    task automatic test_load_reservation();
        q1_addr = 5'd7;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        tick();                                   // edge 1
        rsv_valid = 1'b0;
        total_cnt++;
        if (q1_busy !== 1'b1) $display("FAIL rsv_busy_e1: got %0b want 1", q1_busy);
        else pass_cnt++;
        tick();                                   // edge 2
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1234;
        total_cnt++;
        if (ld_ready !== 1'b1) $display("FAIL ld_ready_empty: got %0b want 1", ld_ready);
        else pass_cnt++;
        tick();                                   // edge 3: push
        ld_valid = 1'b0;
        total_cnt++;
        if ({q1_busy, we} !== 2'b10)
            $display("FAIL ld_e3: got busy/we=%b want 10", {q1_busy, we});
        else pass_cnt++;
        tick();                                   // edge 4: head into output reg
        total_cnt++;
        if ({we, wa, wd, q1_busy} !== {1'b1, 5'd7, 32'h1234, 1'b1})
            $display("FAIL ld_e4: got we=%0b wa=%0d wd=%h busy=%0b want 1/7/1234/1",
                     we, wa, wd, q1_busy);
        else pass_cnt++;
        tick();                                   // edge 5: commit clears bit
        total_cnt++;
        if ({q1_busy, we} !== 2'b00)
            $display("FAIL ld_e5: got busy/we=%b want 00", {q1_busy, we});
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'(i);
            ld_valid  = 1'b1; ld_addr  = 5'(10 + i); ld_data = 32'h100 + 32'(i);
            tick();
            total_cnt++;
            if ({we, wa, wd} !== {1'b1, 5'd3, 32'(i)})
                $display("FAIL sat_alu_%0d: got we=%0b wa=%0d wd=%h want 1/3/%h", i, we, wa, wd, i);
            else pass_cnt++;
            total_cnt++;
            if ({alu_stall, ld_ready} !== ((i == 3) ? 2'b10 : 2'b01))
                $display("FAIL sat_flags_%0d: got stall/rdy=%b", i, {alu_stall, ld_ready});
            else pass_cnt++;
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if ({we, wa, wd} !== {1'b1, 5'(10 + i), 32'h100 + 32'(i)})
                $display("FAIL sat_drain_%0d: got we=%0b wa=%0d wd=%h want 1/%0d/%h",
                         i, we, wa, wd, 10 + i, 32'h100 + 32'(i));
            else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if ({alu_stall, ld_ready} !== 2'b01)
                    $display("FAIL sat_unstall: got stall/rdy=%b want 01", {alu_stall, ld_ready});
                else pass_cnt++;
            end
        end
        tick();
        total_cnt++;
        if (we !== 1'b0) $display("FAIL sat_empty: got we=%0b want 0", we);
        else pass_cnt++;
    endtask

    task automatic test_addr0();
        q1_addr = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        tick();
        idle_inputs();
        total_cnt++;
        if ({we, q1_busy} !== 2'b00)
            $display("FAIL r0_alu: got we/busy=%b want 00", {we, q1_busy});
        else pass_cnt++;
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hAA;
        tick();                                   // r0 response enqueued
        ld_valid = 1'b0;
        tick();                                   // r0 response consumed silently
        total_cnt++;
        if ({we, q1_busy} !== 2'b00)
            $display("FAIL r0_load: got we/busy=%b want 00", {we, q1_busy});
        else pass_cnt++;
        // Three ALU-shadowed pushes must not fill the FIFO if the r0 entry left.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
            ld_valid  = 1'b1; ld_addr  = 5'(20 + i); ld_data = 32'(i);
            tick();
        end
        idle_inputs();
        total_cnt++;
        if ({alu_stall, ld_ready, we, wa} !== {2'b01, 1'b1, 5'd1})
            $display("FAIL r0_count: got stall/rdy=%b we=%0b wa=%0d want 01/1/1",
                     {alu_stall, ld_ready}, we, wa);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({we, wa} !== {1'b1, 5'(20 + i)})
                $display("FAIL r0_drain_%0d: got we=%0b wa=%0d want 1/%0d", i, we, wa, 20 + i);
            else pass_cnt++;
        end
        tick();
    endtask

    task automatic test_collision();
        q2_addr = 5'd9;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h1;
        tick();                                   // push
        ld_valid = 1'b0;
        tick();                                   // in output reg
        total_cnt++;
        if ({we, wa, q2_busy} !== {1'b1, 5'd9, 1'b1})
            $display("FAIL coll_pre: got we=%0b wa=%0d busy=%0b want 1/9/1", we, wa, q2_busy);
        else pass_cnt++;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();                                   // commit and new reservation together
        rsv_valid = 1'b0;
        total_cnt++;
        if (q2_busy !== 1'b1) $display("FAIL coll_setwins: got busy=%0b want 1", q2_busy);
        else pass_cnt++;
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h2;
        tick();
        ld_valid = 1'b0;
        tick();
        total_cnt++;
        if ({we, wa, wd, q2_busy} !== {1'b1, 5'd9, 32'h2, 1'b1})
            $display("FAIL coll_second: got we=%0b wa=%0d wd=%h busy=%0b want 1/9/2/1",
                     we, wa, wd, q2_busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (q2_busy !== 1'b0) $display("FAIL coll_clear: got busy=%0b want 0", q2_busy);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        q1_addr = 5'd12; q2_addr = 5'd13;
        rsv_valid = 1'b1; rsv_addr = 5'd12;
        tick();
        rsv_addr = 5'd13;
        tick();
        rsv_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h77;
            ld_valid  = 1'b1; ld_addr  = 5'(24 + i); ld_data = 32'(i);
            tick();
        end
        idle_inputs();
        total_cnt++;
        if ({we, wa, q1_busy, q2_busy} !== {1'b1, 5'd2, 2'b11})
            $display("FAIL mrst_pre: got we=%0b wa=%0d busy=%b want 1/2/11",
                     we, wa, {q1_busy, q2_busy});
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({we, wa, wd} !== {1'b0, 5'd0, 32'd0})
            $display("FAIL mrst_wr: got we=%0b wa=%0d wd=%h want 0/0/0", we, wa, wd);
        else pass_cnt++;
        total_cnt++;
        if ({ld_ready, alu_stall, q1_busy, q2_busy} !== 4'b1000)
            $display("FAIL mrst_flags: got rdy/stall/b1/b2=%b want 1000",
                     {ld_ready, alu_stall, q1_busy, q2_busy});
        else pass_cnt++;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if ({we, q1_busy, q2_busy} !== 3'b000)
                $display("FAIL mrst_after_%0d: got we/b1/b2=%b want 000", i, {we, q1_busy, q2_busy});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_reservation();
        test_saturation();
        test_addr0();
        test_collision();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side front end for the CPU's 32×32 register file (two combinational read ports, one write port, register 0 hard-wired to zero). It merges single-cycle ALU results and variable-latency load responses into the single register-file write port. Load responses are buffered in a small FIFO. A per-register pending scoreboard lets the issue stage stall on registers whose load has not yet committed. It sits between the execute/memory stages and the register file's `wa`/`wd`/`we` inputs.

## Interface

Parameters:
- `DEPTH`, default 4: load-response FIFO entries; power of two, ≥ 2.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_addr` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `alu_stall` output 1: upstream must hold off; `alu_valid` must be 0 while this is high.
- `ld_valid` input 1: load response offered.
- `ld_ready` output 1: FIFO can accept a response; transfer occurs when `ld_valid && ld_ready`.
- `ld_addr` input 5: load destination register.
- `ld_data` input 32: load data.
- `rsv_valid` input 1: issue stage reserves a load destination.
- `rsv_addr` input 5: register being reserved.
- `q1_addr`, `q2_addr` input 5 each: scoreboard query addresses (rs/rt).
- `q1_busy`, `q2_busy` output 1 each: combinational; pending bit of the queried register.
- `we` output 1: register-file write enable (registered).
- `wa` output 5: register-file write address (registered).
- `wd` output 32: register-file write data (registered).

## Operation

- **Output register.** Holds `we`/`wa`/`wd` plus an internal `src_ld` flag. It is loaded every cycle with the arbitration winner, or with `we=0` if there is none.
- **Arbitration, in priority order:**
  1. FIFO full (count == `DEPTH`): FIFO head wins and `alu_stall=1`.
  2. Otherwise, `alu_valid`: ALU wins.
  3. Otherwise, FIFO non-empty: head wins.
- **`alu_stall`** equals (count == `DEPTH`) and is driven from registered state only.
- **`ld_ready`** equals (count < `DEPTH`) and is driven from registered state only.
- **Address 0.** A winner with address 0 is consumed (FIFO pops / ALU accepted) but produces `we=0`. Responses with `ld_addr==0` are still enqueued.
- **Scoreboard.** 32 bits, bit 0 permanently 0.
  - Set: `rsv_valid && rsv_addr!=0` sets the bit at the clock edge.
  - Clear: the bit for `wa` clears at the edge where `we && src_ld` commits the write into the register file.
  - Same register set and cleared on the same edge: set wins, because a new load owns the register.
- **ALU writes** never modify the scoreboard. An ALU write to a pending register is an upstream protocol error and is not checked.
- **FIFO** is in-order. Simultaneous push and pop leaves the count unchanged.

## Timing

- **ALU path.** `alu_valid` sampled at edge N → `we/wa/wd` valid from N to N+1 → register file written at edge N+1.
- **Load path, minimum latency.** Pushed at edge N → head enters the output register at N+1 → register file written at N+2, and the scoreboard bit clears at N+2.
  - Consequence: `q*_busy` stays high until the register-file contents are valid, so no bypass is needed.
- **Reservation.** `rsv_valid` at edge N → `q*_busy` high from N onward.
- **Full-FIFO behaviour.** A push at edge N that reaches count `DEPTH` raises `alu_stall` and drops `ld_ready` after N. The next edge drains one entry, and both flags clear after that edge unless another push refills the FIFO.
- **Reset.** Asynchronous on `rst_n` low:
  - count 0; scoreboard all 0; `we=0`, `wa=0`, `wd=0`, `src_ld=0`.
  - Resulting outputs: `ld_ready=1`, `alu_stall=0`, `q*_busy=0`.
  - Buffered and in-flight writes are discarded.
  - Deassertion is synchronized externally.

## Structure

- **Shared package `cpu_pkg`:**
  - `REG_ADDR_W=5`, `DATA_W=32`.
  - `wb_req_t` struct `{addr, data}`, used by both the FIFO and the output register.
- **Sub-module `wb_fifo`:** synchronous FIFO of `wb_req_t`, parameter `DEPTH`. Ports: push/pop, head, count, full, empty; same clock and reset as this block.
- **Arbiter, scoreboard and output register** live in `writeback_arbiter` itself.

## Test plan

- **ALU write.** `alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF` at edge 1 → after edge 1: `we=1, wa=5, wd=0xDEADBEEF`; next cycle `we=0`.
- **Load after reservation.** Reserve r7 at edge 1; load response r7/0x1234 pushed at edge 3 → `q1_busy(r7)=1` through edge 5; `we=1, wa=7, wd=0x1234` after edge 4; `busy=0` after edge 5.
- **ALU priority and FIFO saturation.** ALU valid every cycle while 4 loads are pushed → after the 4th push, `alu_stall=1` and `ld_ready=0`; the next edge drains the head load and both flags clear.
- **Address 0.** ALU write to r0, plus a reserved-then-returned load to r0 → `we` never asserts; FIFO count returns to 0; `q_busy(r0)` always 0.
- **Set/clear collision.** Load r9 commits at the same edge as a new `rsv_valid`/`rsv_addr=9` → `q_busy(r9)` remains 1.
- **Mid-operation reset.** Assert `rst_n=0` with 3 entries queued and `we=1` → outputs immediately `we=0, wa=0, wd=0`, `ld_ready=1`, `alu_stall=0`, all busy 0; no writes after release.
